// File: rtl/cmd_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_serializer
//  Purpose  : SD host CMD-line transmitter. Latches a parallel command frame
//             and shifts it out MSB-first, one bit per enabled clock. It can
//             optionally append the CRC7 (x^7+x^3+1) and the end bit '1'.
//             When the frame is done it emits a one-cycle complete pulse.
//  Ports    : clk        - system clock (rising edge)
//             reset      - asynchronous, active-high reset
//             start      - transmit request, sampled only while idle
//             enable     - shift enable; low freezes the frame in place
//             data       - frame payload, bit framesize-1 is sent first
//             framesize  - payload length in bits (clamped to MAX_BITS)
//             crc_en     - append CRC7 + end bit when high at start
//             out        - registered serial output
//             busy       - high while payload/CRC/end bit are on the line
//             complete   - one-cycle pulse after the last bit
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_serializer #(
  parameter int   MAX_BITS   = 136,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                enable,
  input  logic [MAX_BITS-1:0] data,
  input  logic [7:0]          framesize,
  input  logic                crc_en,
  output logic                out,
  output logic                busy,
  output logic                complete
);

  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_CRC    = 3'd2,
    S_ENDBIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [MAX_BITS-1:0] frame, frame_n;
  logic [IDX_W-1:0]    idx, idx_n;       // index of the payload bit now on out
  logic [IDX_W-1:0]    first_idx;
  logic [2:0]          crc_cnt, crc_cnt_n;
  logic [6:0]          crc, crc_n;
  logic [6:0]          crc_step;
  logic                crc_on, crc_on_n;
  logic                out_n, busy_n, complete_n;

  // CRC7 update with the payload bit currently on the line. The bit enters
  // the CRC when it is consumed (its enabled cycle), so stalls never
  // double-count a bit.
  assign crc_step = {crc[5:0], 1'b0} ^ (((crc[6] ^ out) == 1'b1) ? 7'h09 : 7'h00);

  // Position of the first payload bit after clamping oversize frames.
  assign first_idx = (32'(framesize) > MAX_BITS) ? IDX_W'(MAX_BITS - 1)
                                                 : IDX_W'(framesize - 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      frame    <= '0;
      idx      <= '0;
      crc_cnt  <= '0;
      crc      <= '0;
      crc_on   <= 1'b0;
      out      <= IDLE_LEVEL;
      busy     <= 1'b0;
      complete <= 1'b0;
    end else begin
      state    <= state_n;
      frame    <= frame_n;
      idx      <= idx_n;
      crc_cnt  <= crc_cnt_n;
      crc      <= crc_n;
      crc_on   <= crc_on_n;
      out      <= out_n;
      busy     <= busy_n;
      complete <= complete_n;
    end
  end

  // Next-state logic. out always shows the bit of the current cycle; an
  // enabled cycle consumes it and the following edge loads the next one.
  always_comb begin
    state_n    = state;
    frame_n    = frame;
    idx_n      = idx;
    crc_cnt_n  = crc_cnt;
    crc_n      = crc;
    crc_on_n   = crc_on;
    out_n      = out;
    busy_n     = busy;
    complete_n = 1'b0;

    case (state)
      S_IDLE: begin
        out_n  = IDLE_LEVEL;
        busy_n = 1'b0;
        if (start) begin
          frame_n   = data;
          crc_on_n  = crc_en;
          crc_n     = '0;
          crc_cnt_n = '0;
          if (framesize == 8'd0) begin
            state_n    = S_DONE;
            complete_n = 1'b1;
          end else begin
            state_n = S_DATA;
            busy_n  = 1'b1;
            idx_n   = first_idx;
            out_n   = data[first_idx];
          end
        end
      end

      S_DATA: begin
        if (enable) begin
          crc_n = crc_step;
          if (idx == '0) begin
            if (crc_on) begin
              state_n   = S_CRC;
              crc_cnt_n = '0;
              out_n     = crc_step[6];
            end else begin
              state_n    = S_DONE;
              out_n      = IDLE_LEVEL;
              busy_n     = 1'b0;
              complete_n = 1'b1;
            end
          end else begin
            idx_n = idx - 1'b1;
            out_n = frame[idx_n];
          end
        end
      end

      // crc[6] is always the CRC bit on the line; shift to expose the next.
      S_CRC: begin
        if (enable) begin
          if (crc_cnt == 3'd6) begin
            state_n = S_ENDBIT;
            out_n   = 1'b1;
          end else begin
            crc_cnt_n = crc_cnt + 3'd1;
            out_n     = crc[5];
            crc_n     = {crc[5:0], 1'b0};
          end
        end
      end

      S_ENDBIT: begin
        if (enable) begin
          state_n    = S_DONE;
          out_n      = IDLE_LEVEL;
          busy_n     = 1'b0;
          complete_n = 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        out_n   = IDLE_LEVEL;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = S_IDLE;
        out_n   = IDLE_LEVEL;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_serializer
//  Purpose  : Self-checking bench for cmd_serializer. Known SD commands and
//             randomized frames are compared against a reference built from
//             the frame definition: payload bits, CRC7 by polynomial long
//             division, then the end bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_serializer;

  localparam int MB = 136;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          enable;
  logic [MB-1:0] data;
  logic [7:0]    framesize;
  logic          crc_en;
  logic          out;
  logic          busy;
  logic          complete;

  int vectors     = 0;
  int miscompares = 0;

  // Results of the most recent send()
  logic [255:0] cap_vec;
  int           cap_len;
  int           busy_cycles;
  int           comp_n;
  int           comp_count;
  int           hold10;
  bit           idle_bad;

  cmd_serializer #(.MAX_BITS(MB), .IDLE_LEVEL(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .enable    (enable),
    .data      (data),
    .framesize (framesize),
    .crc_en    (crc_en),
    .out       (out),
    .busy      (busy),
    .complete  (complete)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] model_crc(input logic [MB-1:0] d, input int n);
    bit m [0:MB+6];
    bit g [0:7];
    logic [6:0] r;
    g = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < MB + 7; i++) m[i] = 1'b0;
    for (int i = 0; i < n; i++) m[i] = d[n-1-i];
    for (int i = 0; i < n; i++)
      if (m[i]) for (int j = 0; j < 8; j++) m[i+j] = m[i+j] ^ g[j];
    for (int i = 0; i < 7; i++) r[6-i] = m[n+i];
    return r;
  endfunction

  task automatic model_frame(input logic [MB-1:0] d, input int fs, input bit ce,
                             output logic [255:0] v, output int len);
    int n;
    logic [6:0] c;
    n = (fs > MB) ? MB : fs;
    v = '0;
    len = 0;
    for (int i = n - 1; i >= 0; i--) begin v = {v[254:0], d[i]}; len++; end
    if (ce && n > 0) begin
      c = model_crc(d, n);
      for (int i = 6; i >= 0; i--) begin v = {v[254:0], c[i]}; len++; end
      v = {v[254:0], 1'b1};
      len++;
    end
  endtask

  // --------------------------------------------------------------- driver
  // en_mode: 0 = always enabled, 1 = random enable, 2 = 5-cycle stall on bit 10.
  // spur: re-assert start with other data in cycle 15 of the frame.
  task automatic send(input logic [MB-1:0] d, input logic [7:0] fs, input logic ce,
                      input int en_mode, input bit spur);
    int consumed;
    int stall_left;
    bit en;
    consumed = 0; stall_left = 5;
    cap_vec = '0; cap_len = 0; busy_cycles = 0; comp_n = -1; comp_count = 0;
    hold10 = 0; idle_bad = 1'b0;
    @(negedge clk);
    data = d; framesize = fs; crc_en = ce; start = 1'b1;
    enable = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    data = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    framesize = 8'($urandom);
    crc_en = 1'($urandom);
    for (int n = 1; n <= 400; n++) begin
      if (n > 1) @(negedge clk);
      if (complete) begin comp_count++; if (comp_n < 0) comp_n = n; end
      if (busy) busy_cycles++;
      else if (out !== 1'b1) idle_bad = 1'b1;
      if (busy && consumed == 10) hold10++;
      case (en_mode)
        0: en = 1'b1;
        1: en = ($urandom_range(0, 3) != 0);
        default: begin
          if (consumed == 10 && stall_left > 0) begin en = 1'b0; stall_left--; end
          else en = 1'b1;
        end
      endcase
      enable = en;
      if (busy && en) begin cap_vec = {cap_vec[254:0], out}; cap_len++; consumed++; end
      if (spur) begin
        start = (n == 15);
        if (n == 15) begin data = ~d; framesize = 8'd8; crc_en = ~ce; end
      end
      if (comp_n > 0 && n >= comp_n + 2) break;
    end
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    reset = 1'b1; start = 1'b0; enable = 1'b0; data = '0; framesize = '0; crc_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (out !== 1'b1) begin miscompares++; $display("FAIL reset_out got=%b exp=1", out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (complete !== 1'b0) begin miscompares++; $display("FAIL reset_complete got=%b exp=0", complete); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cmd0;
    send(136'h40_0000_0000, 8'd40, 1'b1, 0, 1'b0);
    vectors++; if (cap_len !== 48 || cap_vec !== 256'h4000_0000_0095) begin miscompares++;
      $display("FAIL cmd0_stream got=%h len=%0d exp=400000000095 len=48", cap_vec[47:0], cap_len); end
    vectors++; if (busy_cycles !== 48) begin miscompares++; $display("FAIL cmd0_busy got=%0d exp=48", busy_cycles); end
    vectors++; if (comp_n !== 49 || comp_count !== 1) begin miscompares++;
      $display("FAIL cmd0_complete got cycle=%0d count=%0d exp cycle=49 count=1", comp_n, comp_count); end
    vectors++; if (idle_bad) begin miscompares++; $display("FAIL cmd0_idle got=low exp=high"); end
  endtask

  task automatic test_cmd8_cmd17;
    send(136'h48_0000_01AA, 8'd40, 1'b1, 0, 1'b0);
    vectors++; if (cap_len !== 48 || cap_vec !== 256'h4800_0001_AA87) begin miscompares++;
      $display("FAIL cmd8_stream got=%h len=%0d exp=48000001aa87 len=48", cap_vec[47:0], cap_len); end
    send(136'h51_0000_0000, 8'd40, 1'b1, 0, 1'b0);
    vectors++; if (cap_len !== 48 || cap_vec !== 256'h5100_0000_0055) begin miscompares++;
      $display("FAIL cmd17_stream got=%h len=%0d exp=510000000055 len=48", cap_vec[47:0], cap_len); end
  endtask

  task automatic test_raw;
    send(136'hABC, 8'd12, 1'b0, 0, 1'b0);
    vectors++; if (cap_len !== 12 || cap_vec !== 256'hABC) begin miscompares++;
      $display("FAIL raw_stream got=%h len=%0d exp=abc len=12", cap_vec[11:0], cap_len); end
    vectors++; if (busy_cycles !== 12 || comp_n !== 13) begin miscompares++;
      $display("FAIL raw_timing got busy=%0d complete=%0d exp busy=12 complete=13", busy_cycles, comp_n); end
  endtask

  task automatic test_stall;
    send(136'h40_0000_0000, 8'd40, 1'b1, 2, 1'b0);
    vectors++; if (cap_len !== 48 || cap_vec !== 256'h4000_0000_0095) begin miscompares++;
      $display("FAIL stall_stream got=%h len=%0d exp=400000000095 len=48", cap_vec[47:0], cap_len); end
    vectors++; if (hold10 !== 6) begin miscompares++; $display("FAIL stall_hold got=%0d exp=6", hold10); end
    vectors++; if (comp_n !== 54) begin miscompares++; $display("FAIL stall_complete got=%0d exp=54", comp_n); end
  endtask

  task automatic test_reset_mid;
    bit bad;
    bad = 1'b0;
    @(negedge clk);
    data = 136'h40_0000_0000; framesize = 8'd40; crc_en = 1'b1; start = 1'b1; enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);   // bit 20 is now on the line
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_prebusy got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (out !== 1'b1 || busy !== 1'b0) begin miscompares++;
      $display("FAIL midrst_immediate got out=%b busy=%b exp out=1 busy=0", out, busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (complete !== 1'b0 || busy !== 1'b0 || out !== 1'b1) bad = 1'b1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL midrst_quiet got=activity exp=idle"); end
    send(136'h40_0000_0000, 8'd40, 1'b1, 0, 1'b0);
    vectors++; if (cap_len !== 48 || cap_vec !== 256'h4000_0000_0095 || comp_n !== 49) begin miscompares++;
      $display("FAIL midrst_resend got=%h len=%0d complete=%0d exp=400000000095 len=48 complete=49",
               cap_vec[47:0], cap_len, comp_n); end
  endtask

  task automatic test_zero;
    send(136'h1234, 8'd0, 1'b1, 0, 1'b0);
    vectors++; if (busy_cycles !== 0 || cap_len !== 0) begin miscompares++;
      $display("FAIL zero_busy got busy=%0d bits=%0d exp 0 0", busy_cycles, cap_len); end
    vectors++; if (comp_n !== 1 || comp_count !== 1 || idle_bad) begin miscompares++;
      $display("FAIL zero_complete got cycle=%0d count=%0d idle_bad=%b exp 1 1 0", comp_n, comp_count, idle_bad); end
  endtask

  task automatic test_start_busy;
    send(136'h40_0000_0000, 8'd40, 1'b1, 0, 1'b1);
    vectors++; if (cap_len !== 48 || cap_vec !== 256'h4000_0000_0095 || comp_n !== 49 || comp_count !== 1) begin
      miscompares++;
      $display("FAIL start_busy got=%h len=%0d complete=%0d/%0d exp=400000000095 len=48 complete=49/1",
               cap_vec[47:0], cap_len, comp_n, comp_count); end
  endtask

  task automatic test_oversize;
    logic [MB-1:0] d;
    logic [255:0] ev;
    int el;
    d = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    model_frame(d, 200, 1'b0, ev, el);
    send(d, 8'd200, 1'b0, 0, 1'b0);
    vectors++; if (cap_len !== el || cap_vec !== ev) begin miscompares++;
      $display("FAIL oversize_stream got len=%0d exp len=%0d (data %h)", cap_len, el, d); end
    vectors++; if (busy_cycles !== 136 || comp_n !== 137) begin miscompares++;
      $display("FAIL oversize_timing got busy=%0d complete=%0d exp 136 137", busy_cycles, comp_n); end
  endtask

  task automatic test_random;
    logic [MB-1:0] d;
    logic [7:0]    fs;
    bit            ce;
    logic [255:0]  ev;
    int            el;
    for (int k = 0; k < 24; k++) begin
      d  = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
      fs = (k % 4 == 0) ? 8'($urandom) : 8'($urandom_range(1, 64));
      ce = 1'($urandom);
      model_frame(d, int'(fs), ce, ev, el);
      send(d, fs, ce, 1, 1'b0);
      vectors++; if (cap_len !== el || cap_vec !== ev) begin miscompares++;
        $display("FAIL rand_stream[%0d] fs=%0d crc=%b got len=%0d %h exp len=%0d %h",
                 k, fs, ce, cap_len, cap_vec[143:0], el, ev[143:0]); end
      vectors++; if (comp_n !== busy_cycles + 1 || comp_count !== 1 || idle_bad) begin miscompares++;
        $display("FAIL rand_complete[%0d] got cycle=%0d count=%0d busy=%0d idle_bad=%b exp cycle=%0d count=1",
                 k, comp_n, comp_count, busy_cycles, idle_bad, busy_cycles + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8_cmd17();
    test_raw();
    test_stall();
    test_reset_mid();
    test_zero();
    test_start_busy();
    test_oversize();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_serializer.md
Name: cmd_serializer

Overview:
- Transmit-side counterpart of the command-path deserializer.
- Latches a parallel frame of up to 136 bits and shifts it out MSB-first on a single-bit line, one bit per clk.
- Optionally appends the SD CRC7 and an end bit '1'; pulses complete when done.
- Sits between the command builder and the CMD pad driver in the SD host.

Parameters:
- MAX_BITS, 136, width of the data input and maximum frame length.
- IDLE_LEVEL, 1, value driven on out when not transmitting (CMD line idles high).

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to transmit; sampled only in IDLE.
- enable  input  1  shift enable; low freezes transmission in place.
- data  input  MAX_BITS  frame payload; bits data[framesize-1:0] are sent, bit framesize-1 first.
- framesize  input  8  number of payload bits; latched with start.
- crc_en  input  1  when high at start, append CRC7 plus end bit '1'.
- out  output  1  serial output, registered.
- busy  output  1  high while a frame is in progress.
- complete  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (async, immediate, including mid-frame): state=IDLE, out=IDLE_LEVEL, busy=0, complete=0, CRC register=0, counters=0. The aborted frame is discarded; no complete pulse.
- States: IDLE, DATA, CRC, ENDBIT, DONE.
- IDLE:
  - out=IDLE_LEVEL, busy=0.
  - On posedge with start=1: latch data, framesize and crc_en into internal registers; clear CRC7; go to DATA.
  - Framesize rules at start:
    - framesize=0 goes directly to DONE; no bits are sent.
    - framesize>MAX_BITS is clamped to MAX_BITS.
- DATA:
  - Each posedge with enable=1 drives the next payload bit onto out and feeds it to CRC7 (polynomial x^7+x^3+1, MSB-first).
  - The first payload bit is visible in the cycle after start was sampled; latency from start to first bit is 1 clk.
  - After framesize bits: go to CRC if crc_en was latched high, else DONE.
- CRC: 7 enabled cycles driving CRC7[6] down to CRC7[0]. Then go to ENDBIT.
- ENDBIT: one enabled cycle driving out=1. Then go to DONE.
- DONE: out=IDLE_LEVEL, complete=1 for exactly one cycle, busy=0. Then go to IDLE.
- busy: 1 in DATA, CRC and ENDBIT; 0 in IDLE and DONE.
- enable=0 in DATA, CRC or ENDBIT:
  - out, bit counter and CRC are held.
  - The stalled bit remains on out until the next enabled edge.
- enable has no effect in IDLE or DONE.
- start while busy or in DONE is ignored. Changes on data, framesize or crc_en after latching have no effect.
- start=1 continuously: a new frame is latched on the first IDLE cycle after DONE. The minimum gap between frames is 1 idle cycle.
- Total enabled cycles per frame: framesize, plus 8 when crc_en=1.
- All outputs are registered; no combinational path from inputs to out, busy or complete.

Test Plan:
- CMD0 with crc_en=1: framesize=40, data=0x4000000000, start pulse, enable=1 -> out sequence is 0x400000000095 MSB-first (48 bits). busy is high for 48 cycles; complete pulses on cycle 49 after start.
- CMD8 with crc_en=1: data=0x48000001AA, framesize=40 -> 0x48000001AA87 on out. Separately, CMD17 with arg 0 (data=0x5100000000) -> 0x510000000055.
- Raw frame, crc_en=0: framesize=12, data=0xABC -> out 1010_1011_1100 then idle high. complete pulses 1 cycle after the last bit; exactly 12 busy cycles.
- Stall: CMD0 frame with enable low for 5 cycles after bit 10 -> bit 10 is held for 6 cycles. The output stream equals 0x400000000095 once stall cycles are removed; complete is delayed by 5.
- Reset mid-frame: assert reset at bit 20 of the CMD0 frame -> out=1, busy=0 immediately, no complete. A new start after reset release sends a full, correct frame.
- Edge cases:
  - framesize=0 -> no busy, complete pulse 1 cycle after start, out stays high.
  - start asserted during busy -> ignored; the frame in progress is unchanged.
  - framesize=200 with crc_en=0 -> exactly 136 bits sent.
